// File: rtl/cpu_pkg.sv
// Shared A09 CPU definitions: fetch FSM state encoding and default fetch geometry.
package cpu_pkg;

  localparam int DefDataWidth   = 16;
  localparam int DefAddrWidth   = 8;
  localparam int DefWordSize    = 2;
  localparam int DefResetVector = 0;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

  function automatic logic is_aligned(input int addr, input int word_size);
    return (addr % word_size) == 0;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: program-memory read port, decode-side IR handshake and branch redirect.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = DefAddrWidth
);

  logic                 mem_req;
  logic [AddrWidth-1:0] mem_addr;
  logic                 mem_ack;
  logic [DataWidth-1:0] mem_din;
  logic [DataWidth-1:0] ir;
  logic                 ir_valid;
  logic                 ir_ready;
  logic                 br_ld;
  logic [AddrWidth-1:0] br_addr;
  logic                 fault;

  modport master (
    output mem_req, mem_addr, ir, ir_valid, fault,
    input  mem_ack, mem_din, ir_ready, br_ld, br_addr
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid, fault,
    output mem_ack, mem_din, ir_ready, br_ld, br_addr
  );

endinterface

// File: rtl/pc_register.sv
// Program counter: async reset to the reset vector, branch load wins over sequential increment.
module pc_register #(
  parameter int AddrWidth   = 8,
  parameter int WordSize    = 2,
  parameter int ResetVector = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 incr,
  input  logic [AddrWidth-1:0] load_addr,
  output logic [AddrWidth-1:0] pc
);

  // Increment wraps modulo 2^AddrWidth by construction of the adder width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= AddrWidth'(ResetVector);
    else if (load)
      pc <= load_addr;
    else if (incr)
      pc <= pc + AddrWidth'(WordSize);
  end

endmodule

// File: rtl/fetch_unit.sv
// A09 fetch stage: PC, program-memory request FSM and instruction register.
// Build option FETCH_ALIGN_CHECK_EN: a misaligned branch target raises a sticky fault and halts fetch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DataWidth   = DefDataWidth,
  parameter int AddrWidth   = DefAddrWidth,
  parameter int WordSize    = DefWordSize,
  parameter int ResetVector = DefResetVector
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t         state_q, state_d;
  logic [DataWidth-1:0] ir_q;
  logic [AddrWidth-1:0] pc;
  logic                 take_data;
  logic                 fault;

  pc_register #(
    .AddrWidth  (AddrWidth),
    .WordSize   (WordSize),
    .ResetVector(ResetVector)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bus.br_ld),
    .incr     (take_data),
    .load_addr(bus.br_addr),
    .pc       (pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (bus.br_ld && !is_aligned(int'(bus.br_addr), WordSize))
      fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // A redirect pre-empts both an arriving word and a pending decode handshake.
  always_comb begin
    state_d   = state_q;
    take_data = 1'b0;
    if (bus.br_ld) begin
      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.mem_ack && !fault) begin
            take_data = 1'b1;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.ir_ready)
            state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take_data)
        ir_q <= bus.mem_din;
    end
  end

  assign bus.mem_req  = (state_q == S_REQ) && !fault;
  assign bus.mem_addr = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = (state_q == S_HOLD);
  assign bus.fault    = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle model of the fetch rules plus directed literal checks.
// Honours FETCH_ALIGN_CHECK_EN to match the DUT build.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if #(.DataWidth(16), .AddrWidth(8)) bus ();

  fetch_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int mem_waits = 2;
  int wait_cnt = 0;
  int valid_cycles = 0;
  bit check_en = 1'b0;

  logic [15:0] mem [0:255];
  logic [7:0]  accepted [$];
  logic [15:0] consumed [$];

  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_valid;
  bit          m_fault;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Memory answers after mem_waits idle request cycles with the word at the current address.
  task automatic driveMemory();
    if (bus.mem_req) begin
      if (wait_cnt >= mem_waits) begin
        bus.mem_ack = 1'b1;
        bus.mem_din = mem[bus.mem_addr];
        wait_cnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic br, input logic [7:0] baddr);
    @(posedge clk);
    #1;
    bus.ir_ready = ready;
    bus.br_ld    = br;
    bus.br_addr  = baddr;
    driveMemory();
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  // Reference: one pending-instruction slot, PC advancing by two bytes per accepted word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = 8'h00;
      m_ir    = 16'h0000;
      m_valid = 1'b0;
      m_fault = 1'b0;
    end else if (bus.br_ld) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if ((int'(bus.br_addr) % 2) != 0) m_fault = 1'b1;
`endif
      m_pc    = bus.br_addr;
      m_valid = 1'b0;
    end else if (!m_valid && !m_fault && bus.mem_ack) begin
      m_ir    = bus.mem_din;
      m_pc    = m_pc + 8'd2;
      m_valid = 1'b1;
    end else if (m_valid && bus.ir_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mem_req", bus.mem_req, !m_valid && !m_fault);
      checkOutput("mem_addr", bus.mem_addr, m_pc);
      checkOutput("ir_valid", bus.ir_valid, m_valid);
      checkOutput("fault", bus.fault, m_fault);
      if (m_valid) checkOutput("ir", bus.ir, m_ir);
      if (bus.mem_req && bus.mem_ack && !bus.br_ld) accepted.push_back(bus.mem_addr);
      if (bus.ir_valid && bus.ir_ready && !bus.br_ld) consumed.push_back(bus.ir);
      if (bus.ir_valid) valid_cycles++;
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {8'hA0, 8'(a)};
    bus.mem_ack  = 1'b0;
    bus.mem_din  = 16'h0000;
    bus.ir_ready = 1'b0;
    bus.br_ld    = 1'b0;
    bus.br_addr  = 8'h00;

    // Power-on reset
    @(posedge clk);
    check_en = 1'b1;
    #2;
    checkOutput("rst_mem_req", bus.mem_req, 1'b1);
    checkOutput("rst_mem_addr", bus.mem_addr, 8'h00);
    checkOutput("rst_ir", bus.ir, 16'h0000);
    checkOutput("rst_ir_valid", bus.ir_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cnt = 0;
    sampleNow();
    checkOutput("rel_mem_req", bus.mem_req, 1'b1);
    checkOutput("rel_mem_addr", bus.mem_addr, 8'h00);

    // Sequential fetch, two wait cycles, decode always ready
    valid_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      sampleNow();
      if (consumed.size() >= 3) break;
    end
    checkOutput("seq_count", consumed.size(), 3);
    if (consumed.size() >= 3 && accepted.size() >= 3) begin
      checkOutput("seq_addr0", accepted[0], 8'h00);
      checkOutput("seq_addr1", accepted[1], 8'h02);
      checkOutput("seq_addr2", accepted[2], 8'h04);
      checkOutput("seq_ir0", consumed[0], 16'hA000);
      checkOutput("seq_ir1", consumed[1], 16'hA002);
      checkOutput("seq_ir2", consumed[2], 16'hA004);
    end
    checkOutput("seq_valid_cycles", valid_cycles, 3);

    // Backpressure with zero-wait memory
    mem_waits = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      sampleNow();
      if (bus.ir_valid) break;
    end
    checkOutput("bp_valid", bus.ir_valid, 1'b1);
    checkOutput("bp_ir", bus.ir, 16'hA006);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      sampleNow();
      checkOutput("bp_hold_ir", bus.ir, 16'hA006);
      checkOutput("bp_hold_req", bus.mem_req, 1'b0);
      checkOutput("bp_hold_pc", bus.mem_addr, 8'h08);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sampleNow();
    checkOutput("bp_next_req", bus.mem_req, 1'b1);
    checkOutput("bp_next_addr", bus.mem_addr, 8'h08);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sampleNow();
    checkOutput("bp_next_ir", bus.ir, 16'hA008);

    // Branch colliding with a memory acknowledge
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h40);
    sampleNow();
    checkOutput("col_ack_seen", bus.mem_ack, 1'b1);
    checkOutput("col_old_addr", bus.mem_addr, 8'h0A);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sampleNow();
    checkOutput("col_valid_dropped", bus.ir_valid, 1'b0);
    checkOutput("col_new_addr", bus.mem_addr, 8'h40);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sampleNow();
    checkOutput("col_ir_valid", bus.ir_valid, 1'b1);
    checkOutput("col_ir", bus.ir, 16'hA040);
    applyStimulus(1'b1, 1'b0, 8'h00);

    // Address wrap
    applyStimulus(1'b0, 1'b1, 8'hFE);
    accepted.delete();
    consumed.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      sampleNow();
      if (consumed.size() >= 2) break;
    end
    checkOutput("wrap_count", consumed.size(), 2);
    if (consumed.size() >= 2 && accepted.size() >= 2) begin
      checkOutput("wrap_addr0", accepted[0], 8'hFE);
      checkOutput("wrap_addr1", accepted[1], 8'h00);
      checkOutput("wrap_ir0", consumed[0], 16'hA0FE);
      checkOutput("wrap_ir1", consumed[1], 16'hA000);
    end

    // Reset in the middle of an outstanding request
    mem_waits = 3;
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    #1;
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    checkOutput("mid_rst_req", bus.mem_req, 1'b1);
    checkOutput("mid_rst_addr", bus.mem_addr, 8'h00);
    checkOutput("mid_rst_ir", bus.ir, 16'h0000);
    checkOutput("mid_rst_valid", bus.ir_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cnt = 0;
    consumed.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      sampleNow();
      if (consumed.size() >= 1) break;
    end
    checkOutput("post_rst_count", consumed.size(), 1);
    if (consumed.size() >= 1) checkOutput("post_rst_ir", consumed[0], 16'hA000);

    // Misaligned branch target
    applyStimulus(1'b1, 1'b1, 8'h41);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sampleNow();
    checkOutput("mis_addr", bus.mem_addr, 8'h41);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis_fault", bus.fault, 1'b1);
    checkOutput("mis_req", bus.mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      sampleNow();
      checkOutput("mis_halt_req", bus.mem_req, 1'b0);
      checkOutput("mis_halt_fault", bus.fault, 1'b1);
      checkOutput("mis_halt_valid", bus.ir_valid, 1'b0);
    end
`else
    checkOutput("mis_fault", bus.fault, 1'b0);
    checkOutput("mis_req", bus.mem_req, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      sampleNow();
      if (bus.ir_valid) break;
    end
    checkOutput("mis_valid", bus.ir_valid, 1'b1);
    checkOutput("mis_ir", bus.ir, 16'hA041);
`endif
    #1;
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    checkOutput("final_rst_fault", bus.fault, 1'b0);
    checkOutput("final_rst_req", bus.mem_req, 1'b1);
    checkOutput("final_rst_addr", bus.mem_addr, 8'h00);
    @(posedge clk);
    #1;
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the A09 CPU: owns the program counter, issues word reads to program memory through a request/acknowledge handshake, and holds each fetched instruction in an instruction register presented to the decode stage with a valid/ready handshake. Sits between program memory and the CPU control/decode logic, directly upstream of the execute path. It also accepts branch redirects from control.

## Interface
Parameters:
- DataWidth, 16, instruction/memory data width
- AddrWidth, 8, program address width
- WordSize, 2, bytes per instruction; PC increment
- ResetVector, 0, PC value loaded on reset

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Mem_Req  out  1  read request to program memory
- Mem_Addr  out  AddrWidth  read address; always equals PC
- Mem_Ack  in  1  read complete; qualifies Mem_DIn for the Mem_Addr of the same cycle
- Mem_DIn  in  DataWidth  read data
- IR  out  DataWidth  instruction register
- IR_Valid  out  1  IR holds an instruction not yet consumed
- IR_Ready  in  1  decode accepts IR this cycle
- Br_Ld  in  1  redirect PC to Br_Addr
- Br_Addr  in  AddrWidth  branch target
- Fault  out  1  misaligned branch target (only with FETCH_ALIGN_CHECK_EN)

## Operation
- States: S_REQ (request outstanding), S_HOLD (IR valid, waiting on decode).
- Mem_Req = (state == S_REQ) and not Fault; combinational from state.
- S_REQ, Mem_Ack=1, Br_Ld=0: IR <= Mem_DIn, PC <= PC + WordSize, IR_Valid <= 1, go S_HOLD.
- S_REQ, Mem_Ack=0: hold; Mem_Req stays high any number of wait cycles.
- S_HOLD: IR stable; IR_Valid=1. IR_Ready=1 -> IR_Valid <= 0, go S_REQ. IR_Ready=0 -> hold indefinitely.
- Br_Ld=1 in any state: PC <= Br_Addr, IR_Valid <= 0, go S_REQ. Takes priority over Mem_Ack (data dropped, PC not incremented) and over IR_Ready (no handshake completes).
- PC arithmetic modulo 2^AddrWidth; PC increment wraps (AddrWidth 8: 8'hFE + 2 = 8'h00). No overflow flag.
- IR not cleared on consumption or redirect; only IR_Valid qualifies it.

## Timing
- Reset asserted (low), asynchronously: PC = ResetVector, IR = 0, IR_Valid = 0, state = S_REQ, Fault = 0. Mem_Req = 1 and Mem_Addr = ResetVector while reset is low and first cycle after release.
- Zero-wait memory (Mem_Ack same cycle as request): IR_Valid rises one edge after request; with IR_Ready held high, one instruction every 2 cycles.
- Reset mid-request or mid-hold: all state discarded immediately; any in-flight Mem_Ack ignored.
- Br_Ld effective on the edge it is sampled; new Mem_Addr visible the following cycle.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: Br_Ld with Br_Addr not a multiple of WordSize sets Fault <= 1 (sticky until reset), PC <= Br_Addr, state S_REQ, Mem_Req forced 0 thereafter; fetch halts.
- Undefined: Fault tied to 0; Br_Addr used unchecked, low bits honoured as given.

## Structure
- Shared package cpu_pkg: state encoding constants (S_REQ, S_HOLD), default DataWidth/AddrWidth/WordSize/ResetVector values.
- One sub-module, pc_register: AddrWidth register with async active-low reset to ResetVector, load (Br_Addr) and increment (WordSize) controls, load priority over increment.
- FSM, IR and handshake logic in fetch_unit.

## Test plan
- Reset: hold Reset=0 mid-run -> PC=8'h00, IR=16'h0000, IR_Valid=0, Mem_Req=1, Mem_Addr=8'h00.
- Sequential fetch, memory with 2 wait cycles, IR_Ready=1: addresses 00,02,04 issued; IR equals memory words in order; IR_Valid one cycle per instruction.
- Backpressure: IR_Ready=0 for 5 cycles after IR_Valid -> IR stable, Mem_Req=0, PC unchanged; IR_Ready=1 -> next request at PC+2.
- Branch colliding with Mem_Ack: Br_Ld=1, Br_Addr=8'h40 same cycle as Mem_Ack -> IR_Valid stays 0, next Mem_Addr=8'h40, dropped word never appears.
- Wrap: Br_Addr=8'hFE, fetch two words -> Mem_Addr sequence FE, 00.
- FETCH_ALIGN_CHECK_EN: Br_Addr=8'h41 -> Fault=1 next edge, Mem_Req=0 thereafter until Reset=0.
